subleq_sequencer: RTL and testbench
===================================

// Module: subleq_sequencer
// PURPOSE
//   Instruction sequencer for the SUBLEQ core. Sole master of the word-addressed
//   memory port (req/ack, load/store). Fetches the triple A,B,C at pc..pc+2,
//   reads mem[A] and mem[B], writes mem[B]-mem[A] back, then branches to C if
//   the result is <= 0 (signed), else to pc+3. Sits between top-level run control and memory.
// PARAMETERS
//   W         `WORD_SIZE     data/address width in bits
//   RESET_PC  0              pc value loaded on reset
//   HALT_ADDR {W{1'b1}}      taken branch to this address halts the core
// PORTS
//   clk        in   1  clock, rising edge
//   areset_n   in   1  asynchronous reset, active low
//   run        in   1  level; 1 = execute instructions, 0 = stop at boundary
//   halted     out  1  1 once a taken branch targets HALT_ADDR
//   pc         out  W  address of current/next instruction
//   mem_req    out  1  memory access request
//   mem_load   out  1  read strobe, valid with mem_req
//   mem_store  out  1  write strobe, valid with mem_req
//   mem_addr   out  W  access address
//   mem_wdata  out  W  write data (0 when mem_store=0)
//   mem_rdata  in   W  read data, valid while mem_ack=1 on a load
//   mem_ack    in   1  access complete; may be same cycle as mem_req
// BEHAVIOUR
//   Reset (async, areset_n=0): state=IDLE, pc=RESET_PC, regA/regB/regC/opA=0,
//     halted=0, mem_req=mem_load=mem_store=0, mem_addr=0, mem_wdata=0.
//     Takes effect immediately, mid-access included; in-flight write is dropped.
//   States: IDLE, FETCH_A, FETCH_B, FETCH_C, READ_A, READ_B, WRITE_B, HALT.
//   IDLE:    no request. run=1 -> FETCH_A next edge.
//   FETCH_A: load mem_addr=pc;    ack -> regA<=rdata, FETCH_B.
//   FETCH_B: load mem_addr=pc+1;  ack -> regB<=rdata, FETCH_C.
//   FETCH_C: load mem_addr=pc+2;  ack -> regC<=rdata, READ_A.
//   READ_A:  load mem_addr=regA;  ack -> opA<=rdata, READ_B.
//   READ_B:  load mem_addr=regB;  ack -> res<=rdata-opA (mod 2^W), WRITE_B.
//   WRITE_B: store mem_addr=regB, mem_wdata=res; on ack:
//     le = res[W-1] | (res==0); next_pc = le ? regC : pc+3 (mod 2^W);
//     pc<=next_pc; if le && regC==HALT_ADDR -> HALT (pc still updated);
//     else run=1 -> FETCH_A, run=0 -> IDLE.
//   HALT: halted=1, no requests; sticky until reset; run ignored.
//   Handshake: in memory states mem_req=1 and exactly one of load/store=1;
//     mem_addr/mem_wdata/strobes held stable until the mem_ack edge. No ack
//     -> stay in state (unbounded stall). mem_req=0 in IDLE and HALT.
//   Strobes/address decoded from registered state (Moore); rdata sampled only
//     on the clock edge where mem_ack=1.
//   Latency: 6 cycles/instruction with zero-wait memory; +1 per stall cycle.
//   pc+1, pc+2, pc+3 wrap modulo 2^W; all arithmetic unsigned W-bit except the
//     le test, which treats res as two's complement.
//   run sampled only in IDLE and at WRITE_B completion; deassertion mid-
//     instruction never aborts it. A==B legal (res=0, branch taken).
// TESTING
//   1 Assert areset_n=0 mid-READ_B -> same cycle mem_req=0, pc=RESET_PC,
//     halted=0; release with run=0 -> stays IDLE, no requests.
//   2 W=8, mem[0..2]=3,4,6, mem[3]=2, mem[4]=5, run=1, zero-wait -> store
//     mem[4]=3 on 6th cycle after FETCH_A entry, pc=3, next FETCH_A addr 3.
//   3 mem[3]=5, mem[4]=5 -> mem[4]=0, pc=6 (branch on zero);
//     mem[3]=1, mem[4]=0 -> mem[4]=0xFF, pc=6 (branch on negative).
//   4 C=0xFF with taken branch -> halted=1 after WRITE_B ack, pc=0xFF,
//     mem_req stays 0 for 20 cycles with run=1.
//   5 mem_ack held 0 for 3 cycles in READ_B -> mem_addr=regB stable, no state
//     change, instruction takes 9 cycles; rdata sampled only on ack cycle.
//   6 pc=0xFD, triple at FD,FE,FF, no branch -> pc=0x00; plus run dropped in
//     FETCH_C -> instruction completes with store, then IDLE, mem_req=0.

Source files
------------

// File: rtl/subleq_sequencer_if.sv
// Memory port between the SUBLEQ sequencer (master) and word-addressed memory
// (slave). Load/store strobes qualify mem_req; mem_ack completes an access.
`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif

interface subleq_sequencer_if #(
  parameter int W = `WORD_SIZE
);
  logic         mem_req;
  logic         mem_load;
  logic         mem_store;
  logic [W-1:0] mem_addr;
  logic [W-1:0] mem_wdata;
  logic [W-1:0] mem_rdata;
  logic         mem_ack;

  modport master (
    output mem_req, mem_load, mem_store, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_load, mem_store, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/subleq_sequencer.sv
// SUBLEQ instruction sequencer: fetches A,B,C at pc..pc+2, computes
// mem[B] <= mem[B]-mem[A], branches to C when the result is <= 0 (signed).
// Memory strobes and address are decoded from registered state only.
`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif

module subleq_sequencer #(
  parameter int           W         = `WORD_SIZE,
  parameter logic [W-1:0] RESET_PC  = {W{1'b0}},
  parameter logic [W-1:0] HALT_ADDR = {W{1'b1}}
) (
  input  logic                clk,
  input  logic                areset_n,
  input  logic                run,
  output logic                halted,
  output logic [W-1:0]        pc,
  subleq_sequencer_if.master  mem
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH_A = 3'd1;
  localparam logic [2:0] S_FETCH_B = 3'd2;
  localparam logic [2:0] S_FETCH_C = 3'd3;
  localparam logic [2:0] S_READ_A  = 3'd4;
  localparam logic [2:0] S_READ_B  = 3'd5;
  localparam logic [2:0] S_WRITE_B = 3'd6;
  localparam logic [2:0] S_HALT    = 3'd7;

  localparam logic [W-1:0] ZERO  = {W{1'b0}};
  localparam logic [W-1:0] ONE   = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] TWO   = {{(W-2){1'b0}}, 2'd2};
  localparam logic [W-1:0] THREE = {{(W-2){1'b0}}, 2'd3};

  logic [2:0]   state_q, state_d;
  logic [W-1:0] pc_q,    pc_d;
  logic [W-1:0] rega_q,  rega_d;
  logic [W-1:0] regb_q,  regb_d;
  logic [W-1:0] regc_q,  regc_d;
  logic [W-1:0] opa_q,   opa_d;
  logic [W-1:0] res_q,   res_d;
  logic         le_s;

  // Branch condition: result is negative or zero in two's complement.
  assign le_s = res_q[W-1] | (res_q == ZERO);

  // Next-state and datapath updates; registers only move on mem_ack.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    rega_d  = rega_q;
    regb_d  = regb_q;
    regc_d  = regc_q;
    opa_d   = opa_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH_A;
        else     state_d = S_IDLE;
      end
      S_FETCH_A: begin
        if (mem.mem_ack) begin
          rega_d  = mem.mem_rdata;
          state_d = S_FETCH_B;
        end else begin
          state_d = S_FETCH_A;
        end
      end
      S_FETCH_B: begin
        if (mem.mem_ack) begin
          regb_d  = mem.mem_rdata;
          state_d = S_FETCH_C;
        end else begin
          state_d = S_FETCH_B;
        end
      end
      S_FETCH_C: begin
        if (mem.mem_ack) begin
          regc_d  = mem.mem_rdata;
          state_d = S_READ_A;
        end else begin
          state_d = S_FETCH_C;
        end
      end
      S_READ_A: begin
        if (mem.mem_ack) begin
          opa_d   = mem.mem_rdata;
          state_d = S_READ_B;
        end else begin
          state_d = S_READ_A;
        end
      end
      S_READ_B: begin
        if (mem.mem_ack) begin
          res_d   = mem.mem_rdata - opa_q;
          state_d = S_WRITE_B;
        end else begin
          state_d = S_READ_B;
        end
      end
      S_WRITE_B: begin
        if (mem.mem_ack) begin
          if (le_s) pc_d = regc_q;
          else      pc_d = pc_q + THREE;
          if (le_s && (regc_q == HALT_ADDR)) state_d = S_HALT;
          else if (run)                      state_d = S_FETCH_A;
          else                               state_d = S_IDLE;
        end else begin
          state_d = S_WRITE_B;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore decode of the memory port from the registered state.
  always_comb begin
    mem.mem_req   = 1'b0;
    mem.mem_load  = 1'b0;
    mem.mem_store = 1'b0;
    mem.mem_addr  = ZERO;
    mem.mem_wdata = ZERO;
    case (state_q)
      S_FETCH_A: begin mem.mem_req = 1'b1; mem.mem_load = 1'b1; mem.mem_addr = pc_q;       end
      S_FETCH_B: begin mem.mem_req = 1'b1; mem.mem_load = 1'b1; mem.mem_addr = pc_q + ONE; end
      S_FETCH_C: begin mem.mem_req = 1'b1; mem.mem_load = 1'b1; mem.mem_addr = pc_q + TWO; end
      S_READ_A:  begin mem.mem_req = 1'b1; mem.mem_load = 1'b1; mem.mem_addr = rega_q;     end
      S_READ_B:  begin mem.mem_req = 1'b1; mem.mem_load = 1'b1; mem.mem_addr = regb_q;     end
      S_WRITE_B: begin
        mem.mem_req   = 1'b1;
        mem.mem_store = 1'b1;
        mem.mem_addr  = regb_q;
        mem.mem_wdata = res_q;
      end
      default: begin
        mem.mem_req = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      rega_q  <= ZERO;
      regb_q  <= ZERO;
      regc_q  <= ZERO;
      opa_q   <= ZERO;
      res_q   <= ZERO;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      rega_q  <= rega_d;
      regb_q  <= regb_d;
      regc_q  <= regc_d;
      opa_q   <= opa_d;
      res_q   <= res_d;
    end
  end

  assign halted = (state_q == S_HALT);
  assign pc     = pc_q;

endmodule

// File: tb/tb_subleq_sequencer.sv
// Scoreboard bench for subleq_sequencer (W=8). A SUBLEQ interpreter predicts
// every memory access, the pc after each instruction and the final memory.
module tb_subleq_sequencer;
  logic       clk = 1'b0;
  logic       areset_n;
  logic       run;
  logic       halted;
  logic [7:0] pc;

  subleq_sequencer_if #(.W(8)) mif();

  subleq_sequencer #(.W(8), .RESET_PC(8'h00), .HALT_ADDR(8'hFF)) dut (
    .clk(clk), .areset_n(areset_n), .run(run), .halted(halted), .pc(pc), .mem(mif)
  );

  always #5 clk = ~clk;

  typedef struct { bit st; logic [7:0] addr; logic [7:0] data; int idx; } acc_t;

  acc_t       exp_q[$];
  logic [7:0] exp_pc_q[$];
  bit         exp_halt_q[$];
  logic [7:0] mem[256];
  logic [7:0] refmem[256];
  logic [7:0] pc_m;
  bit         halt_m;
  int vectors = 0, miscompares = 0;
  int cyc = 0, stall_cnt = 0, stall_mode = 0, acc_done = 0, instr_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_acc(input bit st, input logic [7:0] a, input logic [7:0] d, input int idx);
    acc_t e;
    e.st = st; e.addr = a; e.data = d; e.idx = idx;
    exp_q.push_back(e);
  endtask

  // Reference interpreter: one SUBLEQ step per iteration on refmem.
  task automatic model_run(input int n, output int n_exec);
    logic [7:0] a, b, c, r;
    n_exec = 0;
    for (int i = 0; i < n && !halt_m; i++) begin
      a = refmem[pc_m];
      b = refmem[8'(pc_m + 8'd1)];
      c = refmem[8'(pc_m + 8'd2)];
      push_acc(1'b0, pc_m, 8'h00, 0);
      push_acc(1'b0, 8'(pc_m + 8'd1), 8'h00, 1);
      push_acc(1'b0, 8'(pc_m + 8'd2), 8'h00, 2);
      push_acc(1'b0, a, 8'h00, 3);
      push_acc(1'b0, b, 8'h00, 4);
      r = refmem[b] - refmem[a];
      push_acc(1'b1, b, r, 5);
      refmem[b] = r;
      if ($signed(r) <= 0) begin
        pc_m = c;
        if (c == 8'hFF) halt_m = 1'b1;
      end else begin
        pc_m = pc_m + 8'd3;
      end
      exp_pc_q.push_back(pc_m);
      exp_halt_q.push_back(halt_m);
      n_exec++;
    end
  endtask

  // Memory responder: optional wait states, garbage rdata unless acking.
  initial begin
    int wt;
    wt = -1;
    mif.mem_ack = 1'b0;
    mif.mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (!mif.mem_req) begin
        mif.mem_ack = 1'b0; wt = -1; mif.mem_rdata = 8'($urandom);
      end else begin
        if (wt < 0) wt = (stall_mode == 0) ? 0 : (stall_mode == 1) ? int'($urandom_range(0, 3)) : 3;
        if (wt == 0) begin
          mif.mem_ack = 1'b1;
          mif.mem_rdata = mif.mem_load ? mem[mif.mem_addr] : 8'($urandom);
          wt = -1;
        end else begin
          mif.mem_ack = 1'b0; mif.mem_rdata = 8'($urandom); wt--; stall_cnt++;
        end
      end
    end
  end

  // Monitor: compares every requested access against the scoreboard head.
  initial begin
    int fetch_cyc, fetch_stall;
    bit pcchk;
    acc_t e;
    pcchk = 1'b0; fetch_cyc = 0; fetch_stall = 0;
    forever begin
      @(negedge clk); #1;
      if (pcchk && exp_pc_q.size() > 0) begin
        chk("pc_after_instr", pc, exp_pc_q.pop_front());
        chk("halted_after_instr", halted, exp_halt_q.pop_front());
      end
      pcchk = 1'b0;
      if (areset_n && mif.mem_req) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_access", mif.mem_req, 1'b0);
        end else begin
          e = exp_q[0];
          chk("acc_kind", {mif.mem_load, mif.mem_store}, e.st ? 2'b01 : 2'b10);
          chk("acc_addr", mif.mem_addr, e.addr);
          chk("acc_wdata", mif.mem_wdata, e.st ? e.data : 8'h00);
          if (mif.mem_ack) begin
            void'(exp_q.pop_front());
            acc_done++;
            if (e.idx == 0) begin fetch_cyc = cyc; fetch_stall = stall_cnt; end
            if (e.st) begin
              mem[e.addr] = mif.mem_wdata;
              instr_done++;
              pcchk = 1'b1;
              chk("instr_cycles", cyc - fetch_cyc, 5 + stall_cnt - fetch_stall);
            end
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk); #2;
    areset_n = 1'b0; run = 1'b0;
    exp_q.delete(); exp_pc_q.delete(); exp_halt_q.delete();
    refmem = mem; pc_m = 8'h00; halt_m = 1'b0; acc_done = 0; instr_done = 0;
    repeat (2) @(negedge clk);
    #2 areset_n = 1'b1;
  endtask

  task automatic clear_mem();
    foreach (mem[i]) mem[i] = 8'h00;
  endtask

  task automatic load5(input logic [7:0] a, b, c, d3, d4);
    clear_mem();
    mem[0] = a; mem[1] = b; mem[2] = c; mem[3] = d3; mem[4] = d4;
  endtask

  // Run up to n instructions; run drops during FETCH_C of the last one.
  task automatic run_prog(input int n);
    int ne, k, bad;
    model_run(n, ne);
    @(negedge clk); #2; run = 1'b1;
    if (!halt_m) begin
      k = 0;
      while (acc_done < 6 * (ne - 1) + 2 && k < 5000) begin @(negedge clk); #2; k++; end
      run = 1'b0;
    end
    k = 0;
    while (instr_done < ne && k < 5000) begin @(negedge clk); #2; k++; end
    chk("instr_count", instr_done, ne);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #2;
      chk("idle_no_req", mif.mem_req, 1'b0);
    end
    chk("queue_drained", exp_q.size(), 0);
    chk("final_pc", pc, pc_m);
    chk("final_halted", halted, halt_m);
    bad = 0;
    foreach (mem[i]) if (mem[i] !== refmem[i]) bad++;
    chk("mem_image", bad, 0);
  endtask

  initial begin
    int ne, k;
    areset_n = 1'b0; run = 1'b0;
    clear_mem();
    @(negedge clk); #2;
    chk("rst_req", mif.mem_req, 1'b0);
    chk("rst_pc", pc, 8'h00);
    chk("rst_halted", halted, 1'b0);
    chk("rst_addr", mif.mem_addr, 8'h00);
    chk("rst_wdata", mif.mem_wdata, 8'h00);

    // Reset asserted while READ_B is stalled, then idle with run=0.
    load5(8'd3, 8'd4, 8'd6, 8'd2, 8'd5);
    stall_mode = 2;
    do_reset();
    model_run(1, ne);
    run = 1'b1;
    k = 0;
    while (acc_done < 4 && k < 500) begin @(negedge clk); #2; k++; end
    @(negedge clk); #2;
    chk("t1_readb_addr", mif.mem_addr, 8'd4);
    areset_n = 1'b0;
    #1;
    chk("t1_req_async", mif.mem_req, 1'b0);
    chk("t1_pc_async", pc, 8'h00);
    chk("t1_halted_async", halted, 1'b0);
    run = 1'b0;
    exp_q.delete(); exp_pc_q.delete(); exp_halt_q.delete();
    refmem = mem; pc_m = 8'h00; halt_m = 1'b0; acc_done = 0; instr_done = 0;
    @(negedge clk); #2 areset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #2;
      chk("t1_idle_req", mif.mem_req, 1'b0);
      chk("t1_idle_pc", pc, 8'h00);
    end
    chk("t1_mem4_untouched", mem[4], 8'd5);

    // Basic instruction, zero-wait: mem[4]=3, pc=3, then next at 3.
    stall_mode = 0;
    load5(8'd3, 8'd4, 8'd6, 8'd2, 8'd5);
    do_reset();
    run_prog(2);
    chk("t2_mem4", mem[4], 8'h03);
    chk("t2_mem3", mem[3], 8'hFC);

    // Branch on zero and on negative.
    load5(8'd3, 8'd4, 8'd6, 8'd5, 8'd5);
    do_reset();
    run_prog(1);
    chk("t3a_mem4", mem[4], 8'h00);
    chk("t3a_pc", pc, 8'd6);
    load5(8'd3, 8'd4, 8'd6, 8'd1, 8'd0);
    do_reset();
    run_prog(1);
    chk("t3b_mem4", mem[4], 8'hFF);
    chk("t3b_pc", pc, 8'd6);

    // Taken branch to 0xFF halts with run held high.
    load5(8'd3, 8'd3, 8'hFF, 8'd7, 8'd0);
    do_reset();
    run_prog(3);
    chk("t4_halted", halted, 1'b1);
    chk("t4_pc", pc, 8'hFF);

    // Three wait cycles on every access.
    stall_mode = 2;
    load5(8'd3, 8'd4, 8'd6, 8'd2, 8'd5);
    do_reset();
    run_prog(1);
    chk("t5_mem4", mem[4], 8'h03);

    // Jump to 0xFD, fall through past 0xFF to 0x00; run dropped mid-instruction.
    stall_mode = 0;
    clear_mem();
    mem[0] = 8'h10; mem[1] = 8'h10; mem[2] = 8'hFD;
    mem[8'hFD] = 8'h20; mem[8'hFE] = 8'h21; mem[8'hFF] = 8'h40;
    mem[8'h20] = 8'd1; mem[8'h21] = 8'd5;
    do_reset();
    run_prog(2);
    chk("t6_pc_wrap", pc, 8'h00);
    chk("t6_mem21", mem[8'h21], 8'h04);
    chk("t6_not_halted", halted, 1'b0);

    // Random programs with random wait states.
    stall_mode = 1;
    for (int r = 0; r < 8; r++) begin
      foreach (mem[i]) mem[i] = 8'($urandom);
      do_reset();
      run_prog(int'($urandom_range(5, 25)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
